// File: rtl/hack_alu_if.sv
// Operand/control/result bundle for the registered Hack ALU.
// The master drives operands and controls; the slave (the ALU) returns the registered result.
interface hack_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             out_valid;

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no,
    input  out, zr, ng, out_valid
  );

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no,
    output out, zr, ng, out_valid
  );
endinterface

// File: rtl/hack_alu.sv
// Registered Hack ALU: the six control bits pick the computation.
// Result, zero and negative flags appear one cycle after the operands are sampled.
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  hack_alu_if.slave bus
);
  logic [WIDTH-1:0] x1, x2, y1, y2, r, o;
  logic [WIDTH-1:0] out_reg;
  logic             zr_reg;
  logic             ng_reg;
  logic             valid_reg;

  // Pre-conditioning happens strictly in order: zero first, then negate.
  always_comb begin
    x1 = bus.zx ? '0 : bus.x;
    x2 = bus.nx ? ~x1 : x1;
    y1 = bus.zy ? '0 : bus.y;
    y2 = bus.ny ? ~y1 : y1;
    r  = bus.f ? (x2 + y2) : (x2 & y2);
    o  = bus.no ? ~r : r;
  end

  // Flags are taken from the post-negation value so they always agree with out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg   <= '0;
      zr_reg    <= 1'b1;
      ng_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      out_reg   <= o;
      zr_reg    <= (o == '0);
      ng_reg    <= o[WIDTH-1];
      valid_reg <= bus.in_valid;
    end
  end

  assign bus.out       = out_reg;
  assign bus.zr        = zr_reg;
  assign bus.ng        = ng_reg;
  assign bus.out_valid = valid_reg;
endmodule

// File: tb/tb_hack_alu.sv
// Self-checking bench for hack_alu: directed Hack functions, wrap-around, reset
// behaviour and a randomized pipelined stream against an arithmetic reference model.
module tb_hack_alu;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  hack_alu_if #(.WIDTH(16)) bus ();

  hack_alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: complement taken as 65535 - v, addition reduced modulo 65536.
  function automatic logic [15:0] model(input logic [5:0] c, input logic [15:0] xv, input logic [15:0] yv);
    int unsigned a, b, res;
    a = c[5] ? 0 : int'(xv);
    if (c[4]) a = 65535 - a;
    b = c[3] ? 0 : int'(yv);
    if (c[2]) b = 65535 - b;
    if (c[1]) res = (a + b) % 65536;
    else      res = a & b;
    if (c[0]) res = 65535 - res;
    return res[15:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one op (called just after a rising edge), wait one edge, check everything.
  task automatic do_op(input string tag, input logic [5:0] c, input logic [15:0] xv,
                       input logic [15:0] yv, input logic v, input logic use_exp,
                       input logic [15:0] exp_out);
    logic [15:0] e;
    logic        e_valid;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = c;
    bus.x        = xv;
    bus.y        = yv;
    bus.in_valid = v;
    if (!rst_n) begin
      e       = 16'h0000;
      e_valid = 1'b0;
    end else begin
      e       = use_exp ? exp_out : model(c, xv, yv);
      e_valid = v;
    end
    @(posedge clk);
    #1;
    check({tag, ".out"}, bus.out, e);
    check({tag, ".zr"}, {15'd0, bus.zr}, {15'd0, (e == 16'h0000)});
    check({tag, ".ng"}, {15'd0, bus.ng}, {15'd0, e[15]});
    check({tag, ".vld"}, {15'd0, bus.out_valid}, {15'd0, e_valid});
    $display("op %s ctrl=%b x=%h y=%h vld=%b rst_n=%b -> out=%h zr=%b ng=%b out_valid=%b",
             tag, c, xv, yv, v, rst_n, bus.out, bus.zr, bus.ng, bus.out_valid);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.x        = 16'h1234;
    bus.y        = 16'hABCD;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'b000010;
    @(posedge clk);
    #1;

    // Reset held for two cycles with arbitrary, valid-flagged inputs.
    do_op("rst0", 6'b000111, 16'hFFFF, 16'h8001, 1'b1, 1'b1, 16'h0000);
    do_op("rst1", 6'b011111, 16'h7FFF, 16'h0003, 1'b1, 1'b1, 16'h0000);
    rst_n = 1'b1;

    do_op("c_zero",  6'b101010, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'h0000);
    do_op("c_one",   6'b111111, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'h0001);
    do_op("c_m1",    6'b111010, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF);

    do_op("u_x",     6'b001100, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'h0011);
    do_op("u_y",     6'b110000, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'h0003);
    do_op("u_notx",  6'b001101, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'hFFEE);
    do_op("u_negx",  6'b001111, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'hFFEF);
    do_op("u_xp1",   6'b011111, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'h0012);
    do_op("u_ym1",   6'b110010, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'h0002);

    do_op("b_add",   6'b000010, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'h0014);
    do_op("b_xmy",   6'b010011, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'h000E);
    do_op("b_ymx",   6'b000111, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'hFFF2);
    do_op("b_and",   6'b000000, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'h0001);
    do_op("b_or",    6'b010101, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'h0013);

    do_op("wrap0",   6'b000010, 16'hFFFF, 16'h0001, 1'b1, 1'b1, 16'h0000);
    do_op("wrap1",   6'b000010, 16'h7FFF, 16'h0001, 1'b1, 1'b1, 16'h8000);

    // Back-to-back ops with toggling valid, then a mid-stream reset.
    do_op("p0",      6'b000010, 16'h1000, 16'h0234, 1'b0, 1'b1, 16'h1234);
    do_op("p1",      6'b010011, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE);
    do_op("p2",      6'b000000, 16'hF0F0, 16'hFF00, 1'b0, 1'b1, 16'hF000);
    rst_n = 1'b0;
    do_op("p_rst",   6'b111111, 16'h0011, 16'h0003, 1'b1, 1'b1, 16'h0000);
    rst_n = 1'b1;
    do_op("p3",      6'b001101, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF);

    // Randomized stream over all 64 control combinations with occasional resets.
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 19) != 0);
      do_op($sformatf("rnd%0d", i), 6'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom), 1'b0, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
